// File: rtl/div_radix2_pkg.sv
// Shared definitions for the radix-2 restoring divider: FSM encoding,
// iteration count and the ALU function codes that select DIV/DIVU.
package div_radix2_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam int DIV_CYCLES = 32;

    localparam logic [5:0] ALU_DIV  = 6'b011010;
    localparam logic [5:0] ALU_DIVU = 6'b011011;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the
// divisor from the widened remainder and keep or restore the result.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_n_o,
    output logic [WIDTH-1:0] quo_n_o
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] trial_s;

    // The remainder stays below the divisor, so bit WIDTH of the trial is its sign.
    always_comb begin
        shifted_s = {rem_i, quo_i[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, divisor_i};
        if (!trial_s[WIDTH]) begin
            rem_n_o = trial_s[WIDTH-1:0];
            quo_n_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_n_o = shifted_s[WIDTH-1:0];
            quo_n_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_radix2.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; stalls the pipeline
// and returns {remainder, quotient} for the HI/LO write port.
module div_radix2
    import div_radix2_pkg::*;
#(
    parameter int WIDTH = DIV_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic               annul_i,
    input  logic [WIDTH-1:0]   opa_i,
    input  logic [WIDTH-1:0]   opb_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stall_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   dvs_q;
    logic               neg_quo_q;
    logic               neg_rem_q;
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q;

    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quo_d;
    logic [WIDTH-1:0]   opa_mag_s;
    logic [WIDTH-1:0]   opb_mag_s;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? ({WIDTH{1'b0}} - v) : v;
    endfunction

    // Magnitudes are only taken for signed requests; 0x80000000 maps to itself.
    always_comb begin
        opa_mag_s = neg_if(opa_i, signed_i & opa_i[WIDTH-1]);
        opb_mag_s = neg_if(opb_i, signed_i & opb_i[WIDTH-1]);
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_n_o   (rem_d),
        .quo_n_o   (quo_d)
    );

    // Divider FSM: accept, iterate, publish the fixed-up result for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else if (annul_i && (state_q != DIV_END)) begin
            state_q  <= DIV_IDLE;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    result_q <= '0;
                    ready_q  <= 1'b0;
                    if (start_i) begin
                        if (opb_i == '0) begin
                            state_q <= DIV_BYZERO;
                        end else begin
                            rem_q     <= '0;
                            quo_q     <= opa_mag_s;
                            dvs_q     <= opb_mag_s;
                            neg_quo_q <= signed_i & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
                            neg_rem_q <= signed_i & opa_i[WIDTH-1];
                            cnt_q     <= '0;
                            state_q   <= DIV_ON;
                        end
                    end
                end
                DIV_BYZERO: begin
                    result_q <= '0;
                    ready_q  <= 1'b1;
                    state_q  <= DIV_END;
                end
                DIV_ON: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        result_q <= {neg_if(rem_d, neg_rem_q), neg_if(quo_d, neg_quo_q)};
                        ready_q  <= 1'b1;
                        state_q  <= DIV_END;
                    end
                end
                DIV_END: begin
                    result_q <= '0;
                    ready_q  <= 1'b0;
                    state_q  <= DIV_IDLE;
                end
                default: begin
                    result_q <= '0;
                    ready_q  <= 1'b0;
                    state_q  <= DIV_IDLE;
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign stall_o  = start_i & ~ready_q & ~annul_i;

endmodule

// File: tb/tb_div_radix2.sv
// Self-checking bench for div_radix2: directed corner cases plus randomized
// operands compared against an arithmetic reference model.
module tb_div_radix2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgn;
    logic        annul;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [63:0] result;
    logic        ready;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_radix2 #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start),
        .signed_i (sgn),
        .annul_i  (annul),
        .opa_i    (opa),
        .opb_i    (opb),
        .result_o (result),
        .ready_o  (ready),
        .stall_o  (stall)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'h0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        opa   = a;
        opb   = b;
        sgn   = s;
        start = 1'b1;
    endtask

    // Starts a request in the current (IDLE) cycle and waits for the ready pulse.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag);
        int cyc = 0;
        int stalls = 0;
        int lat;
        bit done = 1'b0;
        logic [63:0] exp;
        exp = ref_div(a, b, s);
        lat = (b == 32'd0) ? 2 : 33;
        launch(a, b, s);
        while (!done) begin
            #1;
            if (ready || cyc >= 60) begin
                done = 1'b1;
            end else begin
                if (stall) stalls++;
                @(negedge clk);
                cyc++;
            end
        end
        check_eq({tag, "/latency"}, 64'(cyc), 64'(lat));
        check_eq({tag, "/stall_cycles"}, 64'(stalls), 64'(lat));
        check_eq({tag, "/stall_at_ready"}, 64'(stall), 64'd0);
        check_eq({tag, "/result"}, result, exp);
    endtask

    task automatic idle_cycle();
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int pulses;
        logic [31:0] a, b;
        logic s;

        rst = 1'b1; start = 1'b0; sgn = 1'b0; annul = 1'b0; opa = 32'd0; opb = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset/result", result, 64'h0);
        check_eq("reset/ready", 64'(ready), 64'd0);
        check_eq("reset/stall", 64'(stall), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(32'hFFFF_FFFF, 32'h0000_0010, 1'b0, "divu_ffff_16");      idle_cycle();
        run_op(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, "div_m7_2");          idle_cycle();
        run_op(32'h0000_0007, 32'hFFFF_FFFE, 1'b1, "div_7_m2");          idle_cycle();
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_overflow");      idle_cycle();
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "divu_8000_ffff");    idle_cycle();
        run_op(32'h1234_5678, 32'h0000_0000, 1'b1, "div_by_zero_s");     idle_cycle();
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "div_by_zero_u");     idle_cycle();
        check_eq("literal/divu_ffff_16", ref_div(32'hFFFF_FFFF, 32'h10, 1'b0), 64'h0000_000F_0FFF_FFFF);

        // Abort at cycle 10 of an ON sequence, then a fresh request.
        launch(32'd1000, 32'd7, 1'b0);
        repeat (10) @(negedge clk);
        annul = 1'b1;
        #1;
        check_eq("annul/stall", 64'(stall), 64'd0);
        @(negedge clk);
        annul = 1'b0;
        start = 1'b0;
        #1;
        check_eq("annul/ready", 64'(ready), 64'd0);
        check_eq("annul/result", result, 64'h0);
        run_op(32'hFFFF_FF9C, 32'd7, 1'b1, "after_annul");               idle_cycle();

        // Same scenario with a reset in cycle 10.
        launch(32'd1000, 32'd7, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        #1;
        check_eq("rst_mid/result", result, 64'h0);
        check_eq("rst_mid/ready", 64'(ready), 64'd0);
        check_eq("rst_mid/stall", 64'(stall), 64'd0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (ready) pulses++;
        end
        check_eq("rst_mid/no_pulse", 64'(pulses), 64'd0);

        // Back-to-back with start held high across END.
        run_op(32'd100, 32'd9, 1'b0, "b2b_first");
        opa = 32'hFFFF_FF00;
        opb = 32'd5;
        sgn = 1'b1;
        @(negedge clk);
        #1;
        check_eq("b2b/single_pulse", 64'(ready), 64'd0);
        run_op(32'hFFFF_FF00, 32'd5, 1'b1, "b2b_second");                idle_cycle();

        for (int i = 0; i < 1000; i++) begin
            s = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 7))
                0:       b = 32'($urandom_range(0, 3));
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 255));
                default: b = 32'($urandom);
            endcase
            run_op(a, b, s, "random");
            idle_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
